// File: rtl/link_pulse_pkg.sv
// Shared types and constants for the NLP / FLP link pulse generator.
package link_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_PULSE = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int unsigned FLP_SLOTS  = 33;
  localparam int unsigned SLOT_IDX_W = 6;

  localparam logic MODE_NLP = 1'b0;
  localparam logic MODE_FLP = 1'b1;

endpackage

// File: rtl/pulse_timer.sv
// Loadable saturating down-counter; done_c flags a zero count.
module pulse_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done_c = (cnt_q == '0);

endmodule

// File: rtl/link_pulse_gen.sv
// Periodic 10BASE-T NLP or clause-28 FLP burst generator with a delayed
// go strobe for the link-integrity logic.
module link_pulse_gen
  import link_pulse_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned PULSE_CYC  = 5,
  parameter int unsigned PERIOD_CYC = 800000,
  parameter int unsigned SLOT_CYC   = 3125,
  parameter int unsigned GO_DLY     = 30010,
  parameter int unsigned CNT_W      = $clog2(PERIOD_CYC + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        mode,
  input  logic [15:0] lcw,
  input  logic        tx_active,
  output logic        tx,
  output logic        go,
  output logic        busy,
  output logic        burst_done
);

  localparam int unsigned SLT_W = $clog2(SLOT_CYC + 1);
  localparam int unsigned GO_W  = $clog2(GO_DLY + 1);

  localparam logic [CNT_W-1:0]      PER_LD    = CNT_W'(PERIOD_CYC - 1);
  localparam logic [SLT_W-1:0]      PULSE_LD  = SLT_W'(PULSE_CYC - 1);
  localparam logic [SLT_W-1:0]      GAP_LD    = SLT_W'(SLOT_CYC - PULSE_CYC - 1);
  localparam logic [SLT_W-1:0]      SLOT_LD   = SLT_W'(SLOT_CYC - 1);
  localparam logic [GO_W-1:0]       GO_LD     = GO_W'(GO_DLY - 1);
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(FLP_SLOTS - 1);

  if (!((FLP_SLOTS * SLOT_CYC < PERIOD_CYC) && (PULSE_CYC < SLOT_CYC) && (CLK_FREQ != 0)))
  begin : g_bad_params
    $error("link_pulse_gen: require 33*SLOT_CYC < PERIOD_CYC and PULSE_CYC < SLOT_CYC");
  end

  state_e                  state_q, state_d;
  logic                    mode_q, mode_d;
  logic [15:0]             lcw_q, lcw_d;
  logic [SLOT_IDX_W-1:0]   slot_q, slot_d;
  logic                    abort_q, abort_d;
  logic                    go_arm_q, go_arm_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic                    go_q, go_d;
  logic                    burst_done_q, burst_done_d;

  logic                    per_load, per_done_c;
  logic                    slt_load, slt_done_c;
  logic [SLT_W-1:0]        slt_val;
  logic                    go_load, go_done_c;
  logic                    arm_go;

  // The slot timer times the pulse, then the rest of the slot, so every
  // slot boundary lands SLOT_CYC after the previous one.
  pulse_timer #(.W(CNT_W)) u_per_tmr (
    .clk(clk), .rst_n(rst_n), .load(per_load), .load_val(PER_LD),
    .dec(state_q != ST_IDLE), .done_c(per_done_c)
  );

  pulse_timer #(.W(SLT_W)) u_slt_tmr (
    .clk(clk), .rst_n(rst_n), .load(slt_load), .load_val(slt_val),
    .dec(1'b1), .done_c(slt_done_c)
  );

  pulse_timer #(.W(GO_W)) u_go_tmr (
    .clk(clk), .rst_n(rst_n), .load(go_load), .load_val(GO_LD),
    .dec(go_arm_q), .done_c(go_done_c)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    lcw_d        = lcw_q;
    slot_d       = slot_q;
    abort_d      = abort_q;
    go_arm_d     = go_arm_q;
    go_d         = 1'b0;
    burst_done_d = 1'b0;
    per_load     = 1'b0;
    slt_load     = 1'b0;
    slt_val      = PULSE_LD;
    go_load      = 1'b0;
    arm_go       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_WAIT;
          per_load = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (per_done_c) begin
          per_load = 1'b1;
          if (!tx_active) begin
            state_d  = ST_PULSE;
            mode_d   = mode;
            lcw_d    = lcw;
            slot_d   = '0;
            abort_d  = 1'b0;
            slt_load = 1'b1;
            slt_val  = PULSE_LD;
          end
        end
      end
      ST_PULSE: begin
        // An abort request is remembered so the pulse still runs full width.
        abort_d = abort_q | tx_active | ~en;
        if (slt_done_c) begin
          if (abort_d) begin
            state_d  = en ? ST_WAIT : ST_IDLE;
            per_load = en;
          end else if ((mode_q == MODE_NLP) || (slot_q == LAST_SLOT)) begin
            state_d      = ST_WAIT;
            arm_go       = 1'b1;
            burst_done_d = (mode_q == MODE_FLP);
          end else begin
            state_d  = ST_GAP;
            slt_load = 1'b1;
            slt_val  = GAP_LD;
          end
        end
      end
      ST_GAP: begin
        if (tx_active || !en) begin
          state_d  = en ? ST_WAIT : ST_IDLE;
          per_load = en;
        end else if (slt_done_c) begin
          slot_d   = slot_q + SLOT_IDX_W'(1);
          slt_load = 1'b1;
          // Odd slot 2k+1 carries lcw_q[k]; a zero bit keeps tx low all slot.
          if (!slot_d[0] || lcw_q[slot_q[4:1]]) begin
            state_d = ST_PULSE;
            slt_val = PULSE_LD;
          end else begin
            slt_val = SLOT_LD;
          end
        end
      end
    endcase

    if (!en) begin
      go_arm_d = 1'b0;
    end else if (arm_go) begin
      go_arm_d = 1'b1;
      go_load  = 1'b1;
    end else if (go_arm_q && go_done_c) begin
      go_arm_d = 1'b0;
      go_d     = 1'b1;
    end

    tx_d   = (state_d == ST_PULSE);
    busy_d = (state_d == ST_PULSE) || (state_d == ST_GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_NLP;
      lcw_q        <= '0;
      slot_q       <= '0;
      abort_q      <= 1'b0;
      go_arm_q     <= 1'b0;
      tx_q         <= 1'b0;
      busy_q       <= 1'b0;
      go_q         <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      lcw_q        <= lcw_d;
      slot_q       <= slot_d;
      abort_q      <= abort_d;
      go_arm_q     <= go_arm_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      go_q         <= go_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign tx         = tx_q;
  assign go         = go_q;
  assign busy       = busy_q;
  assign burst_done = burst_done_q;

endmodule
